// File: rtl/spu_issue_scoreboard.sv
// Issue scoreboard for the SPU execute stage: per-register in-flight write counters,
// writeback-port reservation shift register, hazard stall and branch-flush kill.
module spu_issue_scoreboard #(
    parameter int REG_AW = 7,
    parameter int LAT_W  = 3,
    parameter int LAT0   = 2,
    parameter int LAT1   = 4,
    parameter int LAT2   = 6,
    parameter int LAT3   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_ra,
    input  logic [REG_AW-1:0] dec_rb,
    input  logic [REG_AW-1:0] dec_rc,
    input  logic              dec_ra_en,
    input  logic              dec_rb_en,
    input  logic              dec_rc_en,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_rt_en,
    input  logic [1:0]        dec_lat_class,
    input  logic              flush,
    output logic              issue_fire,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rt,
    output logic              ex_rt_en,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rt,
    output logic [15:0]       stall_cnt
);

    localparam int NREG  = 2 ** REG_AW;
    localparam int NSLOT = 2 ** LAT_W;

    logic [LAT_W-1:0]  busy_cnt [NREG];
    logic [NSLOT-1:0]  resv;
    logic [REG_AW-1:0] resv_rt  [NSLOT];

    logic [LAT_W-1:0] lat;
    logic             raw_hit;
    logic             waw_hit;
    logic             port_hit;
    logic             wr_fire;

    always_comb begin
        case (dec_lat_class)
            2'd0:    lat = LAT_W'(LAT0);
            2'd1:    lat = LAT_W'(LAT1);
            2'd2:    lat = LAT_W'(LAT2);
            default: lat = LAT_W'(LAT3);
        endcase
    end

    // A counter of zero means the value is in the write-through register file this cycle.
    always_comb begin
        raw_hit  = (dec_ra_en && (busy_cnt[dec_ra] != '0)) ||
                   (dec_rb_en && (busy_cnt[dec_rb] != '0)) ||
                   (dec_rc_en && (busy_cnt[dec_rc] != '0));
        waw_hit  = dec_rt_en && (busy_cnt[dec_rt] >= lat);
        port_hit = dec_rt_en && resv[lat];
    end

    assign dec_ready  = !flush && !raw_hit && !waw_hit && !port_hit;
    assign issue_fire = dec_valid && dec_ready;
    assign wr_fire    = issue_fire && dec_rt_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) busy_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_fire && (dec_rt == REG_AW'(i)))
                    busy_cnt[i] <= lat - 1'b1;
                else if (busy_cnt[i] != '0)
                    busy_cnt[i] <= busy_cnt[i] - 1'b1;
            end
        end
    end

    // Slot i means "writeback i cycles from now"; a fire of latency L lands in slot L-1 next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv <= '0;
            for (int i = 0; i < NSLOT; i++) resv_rt[i] <= '0;
        end else begin
            for (int i = 0; i < NSLOT - 1; i++) begin
                if (wr_fire && (lat == LAT_W'(i + 1))) begin
                    resv[i]    <= 1'b1;
                    resv_rt[i] <= dec_rt;
                end else begin
                    resv[i]    <= resv[i+1];
                    resv_rt[i] <= resv_rt[i+1];
                end
            end
            resv[NSLOT-1]    <= 1'b0;
            resv_rt[NSLOT-1] <= '0;
        end
    end

    assign wb_valid = resv[0];
    assign wb_rt    = resv_rt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rt     <= '0;
            ex_rt_en  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            ex_valid <= issue_fire;
            ex_rt    <= dec_rt;
            ex_rt_en <= wr_fire;
            if (dec_valid && !dec_ready && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/spu_issue_scoreboard.md
Name: spu_issue_scoreboard

Overview:
- Issue controller in front of the SPU execute stage (128-bit ALU, 128×128-bit register file, 7-bit register specifiers).
- Tracks in-flight writes per register and reserves single-write-port writeback slots.
- Stalls decode on RAW, WAW or writeback-port conflicts, and kills issue on branch flush.
- Drives the registered ex-stage valid and destination, and the writeback strobe.

Parameters:
- REG_AW, 7, register specifier width (2^REG_AW registers).
- LAT_W, 3, latency/counter width; maximum latency LAT_MAX = 2^LAT_W - 1 = 7.
- LAT0, 2, latency of class 0 (simple fixed-point).
- LAT1, 4, latency of class 1 (shift/rotate).
- LAT2, 6, latency of class 2 (byte/permute).
- LAT3, 7, latency of class 3 (single-precision / multiply).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  combinational; issue accepted this cycle.
- dec_ra, dec_rb, dec_rc  in  REG_AW each  source registers.
- dec_ra_en, dec_rb_en, dec_rc_en  in  1 each  source used.
- dec_rt  in  REG_AW  destination register.
- dec_rt_en  in  1  instruction writes rt.
- dec_lat_class  in  2  latency class selecting LAT0..LAT3.
- flush  in  1  taken branch resolved; kill the decode-slot instruction.
- issue_fire  out  1  combinational; equals dec_valid & dec_ready.
- ex_valid  out  1  registered issue_fire.
- ex_rt  out  REG_AW  registered dec_rt.
- ex_rt_en  out  1  registered dec_rt_en & issue_fire.
- wb_valid  out  1  register-file write strobe this cycle.
- wb_rt  out  REG_AW  register-file write address.
- stall_cnt  out  16  saturating count of cycles with dec_valid & !dec_ready.

Behaviour:
- Reset (async, rst_n=0):
  - All busy_cnt[0..127] = 0 and resv[0..LAT_MAX] = 0.
  - ex_valid, ex_rt, ex_rt_en, wb_valid, wb_rt and stall_cnt = 0.
  - Reset asserted mid-operation discards every in-flight reservation; no writeback strobe is produced after release.
- Latency: L = LATn selected by dec_lat_class.
  - An instruction fired in cycle t has wb_valid=1 with wb_rt=its rt in cycle t+L.
  - busy_cnt[rt] is L-1 in cycle t+1, decrements by 1 each cycle, and reaches 0 in cycle t+L.
- busy_cnt update precedence: a load on fire overrides the decrement for the same register. Nonzero counters decrement; zero counters hold.
- RAW hazard: a source with its enable set and busy_cnt[src] != 0. The register file is write-through, so busy_cnt = 0 in the writeback cycle means readable.
- WAW hazard: dec_rt_en and busy_cnt[dec_rt] >= L, i.e. the new write would not land strictly after the old one.
- Port hazard: dec_rt_en and resv[L] = 1 (writeback slot already taken).
- Readiness and firing:
  - dec_ready = !flush & !RAW & !WAW & !port.
  - dec_ready does not depend on dec_valid; issue_fire = dec_valid & dec_ready.
  - Instructions with dec_rt_en = 0 check RAW only.
- Reservation vector (bit i = writeback i cycles from now; per-slot address array resv_rt[i]):
  - Next resv[i] = resv[i+1] | (issue_fire & dec_rt_en & L == i+1), and resv_rt follows the same rule.
  - resv[LAT_MAX] next = 0.
  - wb_valid = resv[0] and wb_rt = resv_rt[0], both registered state (no combinational path from dec_*).
- Flush:
  - Blocks only the current decode slot; already-fired instructions still complete and write back.
  - Flush in the same cycle as a hazard raises no extra condition; stall_cnt still increments if dec_valid.
- stall_cnt saturates at 16'hFFFF.
- Simultaneous events:
  - Writeback to register r and a new fire to r in the same cycle: allowed when WAW passes (busy_cnt[r] = 0 < L); the counter loads L-1.
  - Source equal to dest of the same instruction: RAW is checked against the old counter only.

Test Plan:
- Reset then a class-0 instruction with rt=5 fired at cycle 1 -> wb_valid=1 with wb_rt=5 at cycle 3; busy_cnt[5] reads 1 at cycle 2 and 0 at cycle 3.
- RAW stall: class-3 write to r10 at t=0, then an instruction with ra=10 presented from t=1 -> dec_ready=0 for t=1..6, fire at t=7, stall_cnt=6.
- WAW: class-2 write to r20 at t=0, then a class-0 write to r20 at t=1 -> stalls until busy_cnt[20] < 2 (fire at t=5); class-3 to r20 at t=1 fires immediately.
- Port conflict: class-1 write to r1 at t=0, then class-0 write to r2 at t=2 -> stalls (slot t=4 taken); fires at t=3 with wb at t=5, so writebacks land in order r1@4, r2@5.
- Flush: dec_valid=1 with no hazard and flush=1 -> issue_fire=0, ex_valid=0 next cycle; an earlier in-flight write still produces wb_valid.
- Async reset at t=3 with three writes in flight -> all outputs 0 immediately; no wb_valid after release; the next instruction fires with no stall.
